// File: rtl/alu_operand_seq.sv
// alu_operand_seq: control stage wrapped around the 8-bit ALU (alu8).
// It takes an opcode on start, then fetches operand A and operand B from
// the shared din bus with a valid/ready handshake, and drives all three to
// alu8 from registers. In the EXEC cycle it captures the ALU result into
// acc and the flags {Z,N,C,B}. The following DONE cycle pulses done.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, op_in        operation request (sampled in IDLE) and its opcode
//   din, din_valid      operand bus and its valid qualifier
//   din_ready           high in GET_A / GET_B
//   alu_a/alu_b/alu_op  registered operands and opcode to alu8
//   alu_y/cout/bout     alu8 result, carry out and borrow out
//   acc, flags          last result and {Z,N,C,B} of that result
//   busy, done          not-IDLE indicator; one-cycle completion pulse
//
// Optional build macro ALU_ACC_CHAIN_EN: adds input port chain. When start
// and chain are both high in IDLE, acc is loaded into alu_a and GET_A is
// skipped, so only operand B is fetched.
module alu_operand_seq #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_ACC_CHAIN_EN
  input  logic             chain,
`endif
  input  logic [OP_W-1:0]  op_in,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_bout,
  output logic [WIDTH-1:0] acc,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    EXEC,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   chain_req;

`ifdef ALU_ACC_CHAIN_EN
  assign chain_req = chain;
`else
  assign chain_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = chain_req ? GET_B : GET_A;
        end
      end
      GET_A: begin
        din_ready = 1'b1;
        if (din_valid) begin
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        din_ready = 1'b1;
        if (din_valid) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers. Each one is written only in its own state, so all
  // of them keep their value until a later operation overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      acc    <= '0;
      flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            alu_op <= op_in;
            if (chain_req) begin
              alu_a <= acc;
            end
          end
        end
        GET_A: begin
          if (din_valid) begin
            alu_a <= din;
          end
        end
        GET_B: begin
          if (din_valid) begin
            alu_b <= din;
          end
        end
        EXEC: begin
          acc   <= alu_y;
          flags <= {(alu_y == '0), alu_y[WIDTH-1], alu_cout, alu_bout};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_seq.sv
module tb_alu_operand_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       chain;
  logic [3:0] op_in;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] alu_a, alu_b, acc;
  logic [3:0] alu_op, flags;
  logic [7:0] alu_y;
  logic       alu_cout, alu_bout;
  logic       busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  alu_operand_seq #(.WIDTH(8), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ALU_ACC_CHAIN_EN
    .chain(chain),
`endif
    .op_in(op_in), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_bout(alu_bout),
    .acc(acc), .flags(flags), .busy(busy), .done(done)
  );

  // Stub ALU: opcode bit 1 selects subtract, otherwise add.
  logic [8:0] stub_sum, stub_diff;
  assign stub_sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign stub_diff = {1'b0, alu_a} - {1'b0, alu_b};
  assign alu_y     = alu_op[1] ? stub_diff[7:0] : stub_sum[7:0];
  assign alu_cout  = alu_op[1] ? 1'b0 : stub_sum[8];
  assign alu_bout  = alu_op[1] ? stub_diff[8] : 1'b0;

  always @(negedge clk) if (done) done_cnt++;

  // Reference: result and {Z,N,C,B} from integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    int r;
    logic [7:0] y;
    r = op[1] ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    y = r[7:0];
    return {y, (y == 8'd0), y[7], (!op[1] && r > 255), (op[1] && r < 0)};
  endfunction

  typedef struct {
    logic [7:0] a, b, acc;
    logic [3:0] op, flags;
    bit         ready_ok;
    int         edges_b;
    int         total;
    bit         timeout;
    logic       done_after, busy_after;
  } obs_t;

  // Drives one operation and records what the DUT showed along the way.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int stall_a,
                        input int stall_b, input bit chain_op,
                        input bit poke_start, output obs_t o);
    o.total = 0;
    o.ready_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op_in = op; chain = chain_op;
    @(posedge clk); o.total++; #1;
    start = 1'b0; op_in = 4'($urandom); chain = 1'b0;
    if (!chain_op) begin
      for (int i = 0; i < stall_a; i++) begin
        din = 8'($urandom); din_valid = 1'b0;
        @(negedge clk); if (!(din_ready && busy)) o.ready_ok = 1'b0;
        @(posedge clk); o.total++; #1;
      end
      din = a; din_valid = 1'b1;
      @(negedge clk); if (!din_ready) o.ready_ok = 1'b0;
      @(posedge clk); o.total++; #1;
      din_valid = 1'b0;
    end
    for (int i = 0; i < stall_b; i++) begin
      din = 8'($urandom); din_valid = 1'b0;
      if (poke_start && i == 0) begin start = 1'b1; op_in = 4'd9; end
      else start = 1'b0;
      @(negedge clk); if (!(din_ready && busy)) o.ready_ok = 1'b0;
      @(posedge clk); o.total++; #1;
    end
    start = 1'b0; din = b; din_valid = 1'b1;
    @(negedge clk); if (!din_ready) o.ready_ok = 1'b0;
    @(posedge clk); o.total++; #1;
    din_valid = 1'b0; din = 8'($urandom);
    @(negedge clk);
    o.a = alu_a; o.b = alu_b; o.op = alu_op;
    if (din_ready) o.ready_ok = 1'b0;
    o.edges_b = 0;
    o.timeout = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done) begin o.timeout = 1'b0; break; end
      @(posedge clk); o.edges_b++; o.total++;
      @(negedge clk);
    end
    o.acc = acc; o.flags = flags;
    @(negedge clk);
    o.done_after = done; o.busy_after = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; chain = 1'b0; op_in = '0; din = '0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_op, acc, flags, din_ready, busy, done} !== '0)
      begin errors++;
        $display("FAIL reset_state: got a=%h b=%h op=%h acc=%h f=%b rdy=%b busy=%b done=%b, want all zero",
                 alu_a, alu_b, alu_op, acc, flags, din_ready, busy, done); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    obs_t o;
    int d0;
    d0 = done_cnt;
    run_op(4'd5, 8'h3C, 8'h12, 0, 0, 1'b0, 1'b0, o);
    checks++;
    if ({o.a, o.b, o.op} !== {8'h3C, 8'h12, 4'd5}) begin errors++;
      $display("FAIL basic_exec_operands: got %h %h %h, want 3c 12 5", o.a, o.b, o.op); end
    checks++;
    if ({o.acc, o.flags} !== {8'h4E, 4'b0000}) begin errors++;
      $display("FAIL basic_result: got acc=%h flags=%b, want 4e 0000", o.acc, o.flags); end
    checks++;
    if (o.timeout || o.total != 4) begin errors++;
      $display("FAIL basic_latency: got %0d edges (timeout=%0b), want 4", o.total, o.timeout); end
    checks++;
    if (done_cnt - d0 != 1 || o.done_after !== 1'b0 || o.busy_after !== 1'b0) begin errors++;
      $display("FAIL basic_done_pulse: got %0d pulses, after done=%b busy=%b, want 1 0 0",
               done_cnt - d0, o.done_after, o.busy_after); end
  endtask

  task automatic test_flags;
    obs_t o;
    run_op(4'd0, 8'h80, 8'h80, 0, 0, 1'b0, 1'b0, o);
    checks++;
    if ({o.acc, o.flags} !== {8'h00, 4'b1010}) begin errors++;
      $display("FAIL flags_zero_carry: got acc=%h flags=%b, want 00 1010", o.acc, o.flags); end
    run_op(4'd2, 8'h00, 8'h80, 0, 0, 1'b0, 1'b0, o);
    checks++;
    if ({o.acc, o.flags} !== {8'h80, 4'b0101}) begin errors++;
      $display("FAIL flags_neg_borrow: got acc=%h flags=%b, want 80 0101", o.acc, o.flags); end
  endtask

  task automatic test_stall;
    obs_t o;
    run_op(4'd5, 8'h3C, 8'h12, 3, 3, 1'b0, 1'b0, o);
    checks++;
    if (!o.ready_ok) begin errors++;
      $display("FAIL stall_ready: got din_ready dropped while waiting, want held 1"); end
    checks++;
    if ({o.a, o.b} !== {8'h3C, 8'h12}) begin errors++;
      $display("FAIL stall_operands: got %h %h, want 3c 12", o.a, o.b); end
    checks++;
    if (o.timeout || o.edges_b != 1 || o.total != 10) begin errors++;
      $display("FAIL stall_latency: got %0d edges after B edge, %0d total, want 1 and 10",
               o.edges_b, o.total); end
  endtask

  task automatic test_ignored_start;
    obs_t o;
    int d0;
    d0 = done_cnt;
    run_op(4'd5, 8'h3C, 8'h12, 0, 2, 1'b0, 1'b1, o);
    checks++;
    if (o.op !== 4'd5 || o.acc !== 8'h4E) begin errors++;
      $display("FAIL ignored_start_op: got op=%h acc=%h, want 5 4e", o.op, o.acc); end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || acc !== 8'h4E || flags !== 4'b0000) begin
      errors++;
      $display("FAIL ignored_start_hold: got pulses=%0d busy=%b acc=%h flags=%b, want 1 0 4e 0000",
               done_cnt - d0, busy, acc, flags); end
  endtask

  task automatic test_random;
    obs_t o;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [11:0] exp;
    int sa, sb;
    for (int n = 0; n < 25; n++) begin
      op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      sa = int'($urandom_range(0, 3)); sb = int'($urandom_range(0, 3));
      exp = model(op, a, b);
      run_op(op, a, b, sa, sb, 1'b0, 1'b0, o);
      checks++;
      if ({o.a, o.b, o.op} !== {a, b, op}) begin errors++;
        $display("FAIL rand_operands[%0d]: got %h %h %h, want %h %h %h", n, o.a, o.b, o.op, a, b, op); end
      checks++;
      if ({o.acc, o.flags} !== exp) begin errors++;
        $display("FAIL rand_result[%0d]: got acc=%h flags=%b, want %h %b", n, o.acc, o.flags,
                 exp[11:4], exp[3:0]); end
      checks++;
      if (o.timeout || o.total != sa + sb + 4 || !o.ready_ok) begin errors++;
        $display("FAIL rand_timing[%0d]: got %0d edges ready_ok=%0b, want %0d", n, o.total,
                 o.ready_ok, sa + sb + 4); end
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    @(posedge clk); #1;
    start = 1'b1; op_in = 4'd5;
    @(posedge clk); #1;
    start = 1'b0; din = 8'h3C; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    d0 = done_cnt;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({alu_a, acc, flags, busy, din_ready, done} !== '0) begin errors++;
      $display("FAIL reset_mid_op: got a=%h acc=%h f=%b busy=%b rdy=%b done=%b, want all zero",
               alu_a, acc, flags, busy, din_ready, done); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_mid_no_done: got %0d pulses busy=%b, want 0 0", done_cnt - d0, busy); end
  endtask

`ifdef ALU_ACC_CHAIN_EN
  task automatic test_chain;
    obs_t o;
    run_op(4'd5, 8'h3C, 8'h12, 0, 0, 1'b0, 1'b0, o);
    run_op(4'd5, 8'h00, 8'h01, 0, 0, 1'b1, 1'b0, o);
    checks++;
    if ({o.a, o.b, o.acc} !== {8'h4E, 8'h01, 8'h4F}) begin errors++;
      $display("FAIL chain_result: got a=%h b=%h acc=%h, want 4e 01 4f", o.a, o.b, o.acc); end
    checks++;
    if (o.timeout || o.total != 3) begin errors++;
      $display("FAIL chain_latency: got %0d edges, want 3", o.total); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_stall();
    test_ignored_start();
    test_random();
    test_basic();
    test_reset_mid();
`ifdef ALU_ACC_CHAIN_EN
    test_chain();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
